// File: rtl/fpu_dispatch_pkg.sv
// Shared types and constants for the FPU dispatch front-end.
//   kind_e       : request kind carried on req_kind
//   slot_state_e : per-unit slot state (IDLE -> SEND -> WAIT -> IDLE)
//   OP*          : unit opcodes, forwarded unchanged on u_op
package fpu_dispatch_pkg;

  typedef enum logic [1:0] {
    KIND_EXEC = 2'd0,
    KIND_MOV  = 2'd1,
    KIND_SET  = 2'd2,
    KIND_GET  = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_SEND = 2'd1,
    SLOT_WAIT = 2'd2
  } slot_state_e;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OPFADD = 6'd0;
  localparam logic [OP_W-1:0] OPFSUB = 6'd1;
  localparam logic [OP_W-1:0] OPFMUL = 6'd2;
  localparam logic [OP_W-1:0] OPFNEG = 6'd3;
  localparam logic [OP_W-1:0] OPFCLT = 6'd4;
  localparam logic [OP_W-1:0] OPFTOI = 6'd5;
  localparam logic [OP_W-1:0] OPITOF = 6'd6;

endpackage

// File: rtl/fpu_unit_slot.sv
// One dispatch slot per execution unit: holds a single outstanding operation.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   issue, issue_op/a/b/dst       : load a new operation (only when idle)
//   idle, waiting                 : slot state visible to the issue logic / arbiter
//   u_valid/u_ready, u_op/u_a/u_b : request handshake towards the unit
//   r_valid, grant, r_ready       : result handshake; grant comes from the arbiter
//   dst                           : latched destination register index
module fpu_unit_slot
  import fpu_dispatch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic [AW-1:0]    issue_dst,
  output logic             idle,
  output logic             waiting,
  output logic             u_valid,
  input  logic             u_ready,
  output logic [OP_W-1:0]  u_op,
  output logic [WIDTH-1:0] u_a,
  output logic [WIDTH-1:0] u_b,
  input  logic             r_valid,
  input  logic             grant,
  output logic             r_ready,
  output logic [AW-1:0]    dst
);

  slot_state_e state, state_next;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SLOT_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_IDLE: if (issue)             state_next = SLOT_SEND;
      SLOT_SEND: if (u_ready)           state_next = SLOT_WAIT;
      SLOT_WAIT: if (r_valid && grant)  state_next = SLOT_IDLE;
      default:                          state_next = SLOT_IDLE;
    endcase
  end

  // Operands are captured once at issue and held until the unit takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_op <= '0;
      u_a  <= '0;
      u_b  <= '0;
      dst  <= '0;
    end else if (issue) begin
      u_op <= issue_op;
      u_a  <= issue_a;
      u_b  <= issue_b;
      dst  <= issue_dst;
    end
  end

  assign idle    = (state == SLOT_IDLE);
  assign waiting = (state == SLOT_WAIT);
  assign u_valid = (state == SLOT_SEND);
  assign r_ready = waiting && grant;

endmodule

// File: rtl/fpu_dispatch.sv
// FPU front-end: register file, busy scoreboard, in-order issue to NUNIT
// execution units, out-of-order fixed-priority writeback, GET read path.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   req_*                            : issue request (kind, op, unit, x1, x2, y, data)
//   u_valid/u_ready, u_op, u_a, u_b  : per-unit request channel (flattened)
//   r_valid/r_ready, r_data, r_flag  : per-unit result channel (flattened)
//   get_valid, get_data              : GET result, one-cycle pulse
//   flag                             : last compare result
module fpu_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NREG       = 32,
  parameter int               NUNIT      = 4,
  parameter logic [NUNIT-1:0] FLAG_UNITS = '0,
  localparam int              AW         = $clog2(NREG),
  localparam int              UW         = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_kind,
  input  logic [OP_W-1:0]        req_op,
  input  logic [UW-1:0]          req_unit,
  input  logic [AW-1:0]          req_x1,
  input  logic [AW-1:0]          req_x2,
  input  logic [AW-1:0]          req_y,
  input  logic [WIDTH-1:0]       req_data,
  output logic [NUNIT-1:0]       u_valid,
  input  logic [NUNIT-1:0]       u_ready,
  output logic [OP_W*NUNIT-1:0]  u_op,
  output logic [WIDTH*NUNIT-1:0] u_a,
  output logic [WIDTH*NUNIT-1:0] u_b,
  input  logic [NUNIT-1:0]       r_valid,
  output logic [NUNIT-1:0]       r_ready,
  input  logic [WIDTH*NUNIT-1:0] r_data,
  input  logic [NUNIT-1:0]       r_flag,
  output logic                   get_valid,
  output logic [WIDTH-1:0]       get_data,
  output logic                   flag
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;

  kind_e            kind;
  logic             accept;
  logic             unit_ok;
  logic             unit_is_flag;

  logic [NUNIT-1:0] slot_idle;
  logic [NUNIT-1:0] slot_waiting;
  logic [NUNIT-1:0] slot_issue;
  logic [AW-1:0]    slot_dst [NUNIT];

  logic [NUNIT-1:0] grant;
  logic             wb_fire;
  logic [UW-1:0]    wb_sel;
  logic             wb_write;

  assign kind         = kind_e'(req_kind);
  assign unit_ok      = (32'(req_unit) < NUNIT) && slot_idle[req_unit];
  assign unit_is_flag = FLAG_UNITS[req_unit];

  // Writeback arbiter: lowest-index waiting slot with a valid result wins.
  always_comb begin
    grant   = '0;
    wb_fire = 1'b0;
    wb_sel  = '0;
    for (int i = 0; i < NUNIT; i++) begin
      if (slot_waiting[i] && r_valid[i] && !wb_fire) begin
        grant[i] = 1'b1;
        wb_fire  = 1'b1;
        wb_sel   = UW'(i);
      end
    end
  end

  assign wb_write = wb_fire && !FLAG_UNITS[wb_sel];

  // Issue checks look only at registered busy bits (no bypass). MOV/SET
  // share the single write port with writeback, which takes priority.
  always_comb begin
    req_ready = 1'b0;
    case (kind)
      KIND_EXEC: req_ready = unit_ok && !busy[req_x1] && !busy[req_x2] &&
                             (unit_is_flag || !busy[req_y]);
      KIND_MOV:  req_ready = !busy[req_x1] && !busy[req_y] && !wb_fire;
      KIND_SET:  req_ready = !busy[req_y] && !wb_fire;
      KIND_GET:  req_ready = !busy[req_x1];
      default:   req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid && req_ready;

  for (genvar i = 0; i < NUNIT; i++) begin : g_slot
    assign slot_issue[i] = accept && (kind == KIND_EXEC) && (32'(req_unit) == i);

    fpu_unit_slot #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .issue     (slot_issue[i]),
      .issue_op  (req_op),
      .issue_a   (regs[req_x1]),
      .issue_b   (regs[req_x2]),
      .issue_dst (req_y),
      .idle      (slot_idle[i]),
      .waiting   (slot_waiting[i]),
      .u_valid   (u_valid[i]),
      .u_ready   (u_ready[i]),
      .u_op      (u_op[i*OP_W +: OP_W]),
      .u_a       (u_a[i*WIDTH +: WIDTH]),
      .u_b       (u_b[i*WIDTH +: WIDTH]),
      .r_valid   (r_valid[i]),
      .grant     (grant[i]),
      .r_ready   (r_ready[i]),
      .dst       (slot_dst[i])
    );
  end

  // NOTE: the register file is reset explicitly because its contents are
  // architecturally defined as zero after reset; this keeps it in flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[slot_dst[wb_sel]] <= r_data[wb_sel*WIDTH +: WIDTH];
    end else if (accept && kind == KIND_MOV) begin
      regs[req_y] <= regs[req_x1];
    end else if (accept && kind == KIND_SET) begin
      regs[req_y] <= req_data;
    end
  end

  // A retiring destination is always busy, so it can never equal the y of a
  // newly accepted EXEC; the clear and set never touch the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_write) busy[slot_dst[wb_sel]] <= 1'b0;
      if (accept && kind == KIND_EXEC && !unit_is_flag) busy[req_y] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag      <= 1'b0;
      get_valid <= 1'b0;
      get_data  <= '0;
    end else begin
      if (wb_fire && FLAG_UNITS[wb_sel]) flag <= r_flag[wb_sel];
      get_valid <= accept && (kind == KIND_GET);
      if (accept && kind == KIND_GET) get_data <= regs[req_x1];
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: directed scenarios with manually
// driven units, then randomized traffic against automatic unit models,
// checked against a program-order architectural model of the register file.
module tb_fpu_dispatch;
  import fpu_dispatch_pkg::*;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int NU = 4;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_kind;
  logic [5:0]      req_op;
  logic [1:0]      req_unit;
  logic [4:0]      req_x1, req_x2, req_y;
  logic [W-1:0]    req_data;
  logic [NU-1:0]   u_valid, u_ready;
  logic [6*NU-1:0] u_op;
  logic [W*NU-1:0] u_a, u_b;
  logic [NU-1:0]   r_valid, r_ready;
  logic [W*NU-1:0] r_data;
  logic [NU-1:0]   r_flag;
  logic            get_valid;
  logic [W-1:0]    get_data;
  logic            flag;

  // Unit-side drive: directed (d_*) or automatic unit models (m_*).
  logic            auto_mode;
  logic [NU-1:0]   d_u_ready, d_r_valid, d_r_flag;
  logic [W*NU-1:0] d_r_data;
  logic [NU-1:0]   m_u_ready, m_r_valid, m_r_flag;
  logic [W*NU-1:0] m_r_data;

  assign u_ready = auto_mode ? m_u_ready : d_u_ready;
  assign r_valid = auto_mode ? m_r_valid : d_r_valid;
  assign r_flag  = auto_mode ? m_r_flag  : d_r_flag;
  assign r_data  = auto_mode ? m_r_data  : d_r_data;

  fpu_dispatch #(
    .WIDTH      (W),
    .NREG       (NR),
    .NUNIT      (NU),
    .FLAG_UNITS (4'b0100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_op    (req_op),
    .req_unit  (req_unit),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_y     (req_y),
    .req_data  (req_data),
    .u_valid   (u_valid),
    .u_ready   (u_ready),
    .u_op      (u_op),
    .u_a       (u_a),
    .u_b       (u_b),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .r_flag    (r_flag),
    .get_valid (get_valid),
    .get_data  (get_data),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes observed at each rising edge (pre-edge values).
  logic          acc_last;
  logic [NU-1:0] hs_u, hs_r;
  logic [5:0]    cap_op [NU];
  logic [W-1:0]  cap_a  [NU];
  logic [W-1:0]  cap_b  [NU];

  always @(posedge clk) begin
    acc_last <= req_valid && req_ready;
    hs_u     <= u_valid & u_ready;
    hs_r     <= r_valid & r_ready;
    for (int i = 0; i < NU; i++) begin
      if (u_valid[i] && u_ready[i]) begin
        cap_op[i] <= u_op[i*6 +: 6];
        cap_a[i]  <= u_a[i*W +: W];
        cap_b[i]  <= u_b[i*W +: W];
      end
    end
  end

  // Stand-in arithmetic of the execution units; the reference applies the
  // same function to architectural register values in program order.
  function automatic logic [W-1:0] unit_fn(input logic [5:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    return (a ^ {b[15:0], b[31:16]}) + {26'd0, op};
  endfunction

  // Automatic unit models: random ready, random latency, hold r_valid until taken.
  initial begin : unit_models
    logic [NU-1:0] pend;
    int            cnt [NU];
    logic [W-1:0]  res [NU];
    logic          rf  [NU];
    m_u_ready = '0; m_r_valid = '0; m_r_flag = '0; m_r_data = '0; pend = '0;
    for (int i = 0; i < NU; i++) begin cnt[i] = 0; res[i] = '0; rf[i] = 1'b0; end
    forever begin
      @(negedge clk);
      if (!auto_mode) begin
        m_u_ready = '0; m_r_valid = '0; pend = '0;
      end else begin
        for (int i = 0; i < NU; i++) begin
          if (hs_r[i]) m_r_valid[i] = 1'b0;
          if (hs_u[i]) begin
            pend[i] = 1'b1;
            cnt[i]  = $urandom_range(0, 4);
            res[i]  = unit_fn(cap_op[i], cap_a[i], cap_b[i]);
            rf[i]   = cap_a[i] < cap_b[i];
          end
          if (pend[i] && !m_r_valid[i]) begin
            if (cnt[i] == 0) begin
              m_r_valid[i]         = 1'b1;
              m_r_data[i*W +: W]   = res[i];
              m_r_flag[i]          = rf[i];
              pend[i]              = 1'b0;
            end else begin
              cnt[i]--;
            end
          end
          m_u_ready[i] = ($urandom_range(0, 2) != 0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] k, input logic [5:0] op, input logic [1:0] un,
                         input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] y,
                         input logic [W-1:0] data);
    req_kind = k; req_op = op; req_unit = un;
    req_x1 = x1; req_x2 = x2; req_y = y; req_data = data;
    req_valid = 1'b1;
  endtask

  // Present a request until accepted (bounded); returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] k, input logic [5:0] op, input logic [1:0] un,
                       input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] y,
                       input logic [W-1:0] data);
    int n;
    set_req(k, op, un, x1, x2, y, data);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 300);
    check("issue_accepted", acc_last, 1'b1);
    req_valid = 1'b0;
  endtask

  logic [W-1:0] mreg [NR];
  logic         mflag;

  initial begin : main
    logic [1:0] k;
    logic [5:0] op;
    logic [1:0] un;
    logic [4:0] x1, x2, y;
    logic [W-1:0] data;

    auto_mode = 1'b0;
    d_u_ready = '0; d_r_valid = '1; d_r_flag = '0; d_r_data = '0;
    req_valid = 1'b0; req_kind = 2'd0; req_op = '0; req_unit = '0;
    req_x1 = '0; req_x2 = '0; req_y = '0; req_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state (r_valid held high: idle slots must not accept results).
    check("reset_u_valid",   u_valid,   4'b0);
    check("reset_r_ready",   r_ready,   4'b0);
    check("reset_get_valid", get_valid, 1'b0);
    check("reset_get_data",  get_data,  32'h0);
    check("reset_flag",      flag,      1'b0);
    check("reset_req_ready", req_ready, 1'b1);
    d_r_valid = '0;

    // SET then GET.
    issue(KIND_SET, 6'd0, 2'd0, 5'd0, 5'd0, 5'd3, 32'h3F80_0000);
    issue(KIND_GET, 6'd0, 2'd0, 5'd3, 5'd0, 5'd0, 32'h0);
    check("get_valid_pulse", get_valid, 1'b1);
    check("get_r3",          get_data,  32'h3F80_0000);
    tick();
    check("get_valid_drop",  get_valid, 1'b0);

    // EXEC unit0 r5 = r3 op r3; dependent GET stalls until after writeback.
    issue(KIND_EXEC, OPFADD, 2'd0, 5'd3, 5'd3, 5'd5, 32'h0);
    check("exec_u_valid", u_valid[0], 1'b1);
    check("exec_u_req",   {u_op[5:0], u_a[31:0], u_b[31:0]}, {OPFADD, 32'h3F80_0000, 32'h3F80_0000});
    d_u_ready[0] = 1'b1;
    tick();
    d_u_ready[0] = 1'b0;
    set_req(KIND_GET, 6'd0, 2'd0, 5'd5, 5'd0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("dep_get_stall", req_ready, 1'b0);
      tick();
    end
    d_r_valid[0] = 1'b1;
    d_r_data[31:0] = 32'h4000_0000;
    #1;
    check("wb0_r_ready",     r_ready,   4'b0001);
    check("dep_get_wb_cyc",  req_ready, 1'b0);
    tick();
    d_r_valid[0] = 1'b0;
    #1;
    check("dep_get_ready",   req_ready, 1'b1);
    tick();
    check("dep_get_acc",     acc_last,  1'b1);
    req_valid = 1'b0;
    check("dep_get_valid",   get_valid, 1'b1);
    check("dep_get_r5",      get_data,  32'h4000_0000);

    // Simultaneous results from units 0 and 1: unit0 first, unit1 next cycle.
    issue(KIND_EXEC, OPFSUB, 2'd0, 5'd3, 5'd3, 5'd6, 32'h0);
    issue(KIND_EXEC, OPFMUL, 2'd1, 5'd3, 5'd5, 5'd7, 32'h0);
    d_u_ready = 4'b0011;
    tick();
    d_u_ready = '0;
    d_r_valid = 4'b0011;
    d_r_data[31:0]  = 32'h1111_1111;
    d_r_data[63:32] = 32'h2222_2222;
    #1;
    check("arb_first",  r_ready, 4'b0001);
    tick();
    d_r_valid[0] = 1'b0;
    #1;
    check("arb_second", r_ready, 4'b0010);
    tick();
    d_r_valid = '0;
    issue(KIND_GET, 6'd0, 2'd0, 5'd6, 5'd0, 5'd0, 32'h0);
    check("arb_r6", get_data, 32'h1111_1111);
    issue(KIND_GET, 6'd0, 2'd0, 5'd7, 5'd0, 5'd0, 32'h0);
    check("arb_r7", get_data, 32'h2222_2222);

    // Flag unit2: no busy bit, no register write, flag updated.
    issue(KIND_EXEC, OPFCLT, 2'd2, 5'd3, 5'd5, 5'd9, 32'h0);
    set_req(KIND_GET, 6'd0, 2'd0, 5'd9, 5'd0, 5'd0, 32'h0);
    #1;
    check("flag_no_busy", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    d_u_ready[2] = 1'b1;
    tick();
    d_u_ready[2] = 1'b0;
    d_r_valid[2] = 1'b1;
    d_r_flag[2]  = 1'b1;
    d_r_data[95:64] = 32'hDEAD_BEEF;
    tick();
    d_r_valid = '0;
    d_r_flag  = '0;
    check("flag_set", flag, 1'b1);
    issue(KIND_GET, 6'd0, 2'd0, 5'd9, 5'd0, 5'd0, 32'h0);
    check("flag_no_reg_write", get_data, 32'h0);

    // Unit3 holds u_ready low: request stable, second EXEC to unit3 stalled.
    issue(KIND_EXEC, OPFMUL, 2'd3, 5'd3, 5'd5, 5'd10, 32'h0);
    set_req(KIND_EXEC, OPFADD, 2'd3, 5'd3, 5'd3, 5'd11, 32'h0);
    #1;
    for (int c = 0; c < 5; c++) begin
      check("send_hold", {u_valid[3], u_op[23:18], u_a[127:96], u_b[127:96]},
            {1'b1, OPFMUL, 32'h3F80_0000, 32'h4000_0000});
      check("same_unit_stall", req_ready, 1'b0);
      tick();
    end
    d_u_ready[3] = 1'b1;
    tick();
    d_u_ready[3] = 1'b0;
    check("wait_stall", req_ready, 1'b0);
    d_r_valid[3] = 1'b1;
    d_r_data[127:96] = 32'h3333_3333;
    tick();
    d_r_valid = '0;
    #1;
    check("slot_free_ready", req_ready, 1'b1);
    tick();
    check("slot_reissue_acc", acc_last, 1'b1);
    req_valid = 1'b0;
    issue(KIND_GET, 6'd0, 2'd0, 5'd10, 5'd0, 5'd0, 32'h0);
    check("unit3_r10", get_data, 32'h3333_3333);

    // Reset while unit0 waits: late result ignored, everything cleared.
    issue(KIND_EXEC, OPFSUB, 2'd0, 5'd3, 5'd3, 5'd12, 32'h0);
    d_u_ready[0] = 1'b1;
    tick();
    d_u_ready[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_u_valid", u_valid, 4'b0);
    check("rst_flag",    flag,    1'b0);
    tick();
    rst = 1'b0;
    d_r_valid = 4'b0001;
    d_r_data[31:0] = 32'h7777_7777;
    #1;
    check("rst_late_r_ready", r_ready, 4'b0);
    tick();
    check("rst_late_r_ready2", r_ready, 4'b0);
    d_r_valid = '0;
    for (int r = 0; r < NR; r++) begin
      issue(KIND_GET, 6'd0, 2'd0, 5'(r), 5'd0, 5'd0, 32'h0);
      check("rst_reg_zero", get_data, 32'h0);
    end
    check("rst_flag_after", flag, 1'b0);

    // Randomized traffic against the architectural model.
    for (int r = 0; r < NR; r++) mreg[r] = '0;
    mflag = 1'b0;
    auto_mode = 1'b1;
    for (int t = 0; t < 300; t++) begin
      k    = 2'($urandom_range(0, 3));
      op   = 6'($urandom_range(0, 6));
      un   = 2'($urandom_range(0, 3));
      x1   = 5'($urandom_range(0, 7));
      x2   = 5'($urandom_range(0, 7));
      y    = 5'($urandom_range(0, 7));
      data = $urandom;
      issue(k, op, un, x1, x2, y, data);
      case (k)
        KIND_EXEC: begin
          if (un == 2'd2) mflag = mreg[x1] < mreg[x2];
          else            mreg[y] = unit_fn(op, mreg[x1], mreg[x2]);
        end
        KIND_MOV: mreg[y] = mreg[x1];
        KIND_SET: mreg[y] = data;
        default: begin
          check("rand_get_valid", get_valid, 1'b1);
          check("rand_get_data",  get_data,  mreg[x1]);
        end
      endcase
    end
    repeat (60) tick();
    for (int r = 0; r < 8; r++) begin
      issue(KIND_GET, 6'd0, 2'd0, 5'(r), 5'd0, 5'd0, 32'h0);
      check("final_reg", get_data, mreg[r]);
    end
    check("final_flag", flag, mflag);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
